// File: rtl/mem_ctrl.sv
// mem_ctrl: the only owner of the byte-wide RAM/IO port. It arbitrates
// between the load-store buffer and instruction fetch, and turns each request
// into 1, 2 or 4 single-byte accesses, least significant byte first.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              lsb_en,
    input  logic              lsb_rw,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [2:0]        lsb_len,
    input  logic [31:0]       lsb_w_data,
    output logic              lsb_done,
    output logic [31:0]       lsb_r_data,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic              owner_if_q, owner_if_d;
    logic              io_q, io_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              lsb_done_q, lsb_done_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       lsb_r_data_q, lsb_r_data_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              stalled_q;
    logic [7:0]        din_sav_q;

    logic        accept_lsb, accept_if;
    logic        rd_final, rd_abort, wr_go, wr_final;
    logic [7:0]  rd_byte;
    logic [31:0] rd_word;

    // Any length other than 1 or 2 bytes is a full word; store it as the last byte index.
    function automatic logic [1:0] len_to_last(input logic [2:0] len);
        case (len)
            3'd1:    return 2'd0;
            3'd2:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // A requester whose done pulse is showing has a stale enable and is skipped.
    assign accept_lsb = lsb_en && !lsb_done_q;
    assign accept_if  = if_en && !if_done_q && !rollback;
    assign rd_final   = (cnt_q == ({1'b0, last_q} + 3'd1));
    assign rd_abort   = owner_if_q && rollback;
    assign wr_go      = mem_wr_q && !(io_q && io_buffer_full);
    assign wr_final   = (cnt_q[1:0] == last_q);

    // The byte that arrived on the first frozen cycle is replayed on resume,
    // because by then mem_din already reflects the next address.
    assign rd_byte = stalled_q ? din_sav_q : mem_din;

    // Merge the byte for the address issued last cycle into the read word.
    always_comb begin
        rd_word = rdata_q;
        case (cnt_q)
            3'd1:    rd_word[7:0]   = rd_byte;
            3'd2:    rd_word[15:8]  = rd_byte;
            3'd3:    rd_word[23:16] = rd_byte;
            3'd4:    rd_word[31:24] = rd_byte;
            default: rd_word = rdata_q;
        endcase
    end

    // State register; rst beats rdy, and rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            owner_if_q   <= 1'b0;
            io_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_done_q    <= 1'b0;
            lsb_r_data_q <= '0;
            if_data_q    <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            owner_if_q   <= owner_if_d;
            io_q         <= io_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            lsb_done_q   <= lsb_done_d;
            if_done_q    <= if_done_d;
            lsb_r_data_q <= lsb_r_data_d;
            if_data_q    <= if_data_d;
        end
    end

    // Bus-side bookkeeping that keeps the read byte caught during a freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            stalled_q <= 1'b0;
            din_sav_q <= '0;
        end else begin
            stalled_q <= !rdy;
            if (!rdy && !stalled_q) begin
                din_sav_q <= mem_din;
            end
        end
    end

    // Next-state logic: LSB wins arbitration, only a fetch read is aborted by rollback.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_lsb)     state_d = lsb_rw ? WRITE : READ;
                else if (accept_if) state_d = READ;
            end
            READ: begin
                if (rd_abort)      state_d = FLUSH;
                else if (rd_final) state_d = IDLE;
            end
            WRITE: begin
                if (wr_go && wr_final) state_d = IDLE;
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic: latch the request, walk the bytes, pulse done.
    always_comb begin
        cnt_d        = cnt_q;
        last_d       = last_q;
        owner_if_d   = owner_if_q;
        io_d         = io_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        lsb_done_d   = 1'b0;
        if_done_d    = 1'b0;
        lsb_r_data_d = lsb_r_data_q;
        if_data_d    = if_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept_lsb) begin
                    owner_if_d = 1'b0;
                    addr_d     = lsb_addr;
                    last_d     = len_to_last(lsb_len);
                    wdata_d    = lsb_w_data;
                    io_d       = (lsb_addr >= IO_BASE);
                    cnt_d      = '0;
                    rdata_d    = '0;
                    mem_a_d    = lsb_addr;
                    mem_dout_d = lsb_w_data[7:0];
                    mem_wr_d   = lsb_rw;
                end else if (accept_if) begin
                    owner_if_d = 1'b1;
                    addr_d     = if_addr;
                    last_d     = 2'd3;
                    io_d       = 1'b0;
                    cnt_d      = '0;
                    rdata_d    = '0;
                    mem_a_d    = if_addr;
                    mem_wr_d   = 1'b0;
                end
            end
            READ: begin
                mem_wr_d = 1'b0;
                if (rd_abort) begin
                    cnt_d = '0;
                end else begin
                    rdata_d = rd_word;
                    if (rd_final) begin
                        if (owner_if_q) begin
                            if_done_d = 1'b1;
                            if_data_d = rd_word;
                        end else begin
                            lsb_done_d   = 1'b1;
                            lsb_r_data_d = rd_word;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if ({1'b0, last_q} > cnt_q) begin
                            mem_a_d = addr_q + ADDR_W'(cnt_q + 3'd1);
                        end
                    end
                end
            end
            WRITE: begin
                if (wr_go) begin
                    if (wr_final) begin
                        mem_wr_d   = 1'b0;
                        lsb_done_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        mem_a_d    = addr_q + ADDR_W'(cnt_q + 3'd1);
                        mem_dout_d = byte_of(wdata_q, cnt_q[1:0] + 2'd1);
                        mem_wr_d   = 1'b1;
                    end
                end
            end
            FLUSH: begin
                mem_wr_d = 1'b0;
            end
            default: begin
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // The write strobe is masked by rdy and, for IO, by the sink being full,
    // so a withheld byte stays pending in the registers.
    assign mem_wr     = mem_wr_q && rdy && !(io_q && io_buffer_full);
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign lsb_done   = lsb_done_q;
    assign lsb_r_data = lsb_r_data_q;
    assign if_done    = if_done_q;
    assign if_data    = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte RAM model, a response
// scoreboard and a write log.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        lsb_en, lsb_rw;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_w_data;
    logic        lsb_done;
    logic [31:0] lsb_r_data;
    logic        if_en;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk_data;
    } rsp_t;

    bit [7:0] ram [bit [31:0]];
    wr_t      wr_log[$];
    wr_t      wr_exp[$];
    rsp_t     lsb_sb[$];
    rsp_t     if_sb[$];
    int       cyc = 0;
    int       lsb_done_cnt = 0;
    int       if_done_cnt = 0;
    int       compared = 0;
    int       mismatched = 0;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .lsb_en         (lsb_en),
        .lsb_rw         (lsb_rw),
        .lsb_addr       (lsb_addr),
        .lsb_len        (lsb_len),
        .lsb_w_data     (lsb_w_data),
        .lsb_done       (lsb_done),
        .lsb_r_data     (lsb_r_data),
        .if_en          (if_en),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, writes logged with the cycle they land in.
    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wr_log.push_back('{cyc, mem_a, mem_dout});
        end
        if (lsb_done) lsb_done_cnt++;
        if (if_done) if_done_cnt++;
        cyc++;
    end

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive an LSB request in the current cycle and record what should come back.
    task automatic apply_stimulus(input bit rw, input logic [31:0] addr, input logic [2:0] len,
                                  input logic [31:0] wdata, input int lat, input logic [31:0] exp_data);
        lsb_en     = 1'b1;
        lsb_rw     = rw;
        lsb_addr   = addr;
        lsb_len    = len;
        lsb_w_data = wdata;
        lsb_sb.push_back('{cyc + lat, exp_data, !rw});
    endtask

    task automatic wait_lsb(input string tag, input bit hold_en);
        bit   seen = 1'b0;
        rsp_t e;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (lsb_done) begin
                seen = 1'b1;
                e = lsb_sb.pop_front();
                check_output({tag, " done cycle"}, 32'(cyc), 32'(e.cyc));
                if (e.chk_data) check_output({tag, " load data"}, lsb_r_data, e.data);
                if (!hold_en) lsb_en = 1'b0;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: lsb_done observed 0 required 1 within 40 cycles", tag);
            lsb_en = 1'b0;
            if (lsb_sb.size() > 0) void'(lsb_sb.pop_front());
        end
    endtask

    task automatic wait_if(input string tag);
        bit   seen = 1'b0;
        rsp_t e;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (if_done) begin
                seen = 1'b1;
                e = if_sb.pop_front();
                check_output({tag, " done cycle"}, 32'(cyc), 32'(e.cyc));
                check_output({tag, " fetch data"}, if_data, e.data);
                if_en = 1'b0;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: if_done observed 0 required 1 within 40 cycles", tag);
            if_en = 1'b0;
            if (if_sb.size() > 0) void'(if_sb.pop_front());
        end
    endtask

    task automatic check_writes(input string tag);
        wr_t o, e;
        check_output({tag, " write count"}, 32'(wr_log.size()), 32'(wr_exp.size()));
        while (wr_exp.size() > 0 && wr_log.size() > 0) begin
            o = wr_log.pop_front();
            e = wr_exp.pop_front();
            check_output({tag, " write cycle"}, 32'(o.cyc), 32'(e.cyc));
            check_output({tag, " write addr"}, o.addr, e.addr);
            check_output({tag, " write data"}, 32'(o.data), 32'(e.data));
        end
        wr_log.delete();
        wr_exp.delete();
    endtask

    initial begin
        int a;
        int base;

        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h0]   = 8'h93; ram[32'h1]   = 8'h00; ram[32'h2]   = 8'h10; ram[32'h3]   = 8'h00;
        ram[32'h10]  = 8'hEF; ram[32'h11]  = 8'hBE;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        lsb_en = 1'b0; lsb_rw = 1'b0; lsb_addr = '0; lsb_len = 3'd4; lsb_w_data = '0;
        if_en = 1'b0; if_addr = '0;
        repeat (3) step();
        check_output("reset lsb_done", 32'(lsb_done), 32'd0);
        check_output("reset if_done", 32'(if_done), 32'd0);
        check_output("reset mem_wr", 32'(mem_wr), 32'd0);
        check_output("reset mem_a", mem_a, 32'h0);
        check_output("reset mem_dout", 32'(mem_dout), 32'h0);
        check_output("reset lsb_r_data", lsb_r_data, 32'h0);
        check_output("reset if_data", if_data, 32'h0);
        rst = 1'b0;
        step();
        wr_log.delete();

        // Word load, done exactly six cycles after accept
        step();
        apply_stimulus(1'b0, 32'h100, 3'd4, 32'h0, 6, 32'h44332211);
        wait_lsb("lw", 1'b0);
        check_writes("lw");

        // Byte store touches exactly one byte
        step();
        a = cyc;
        apply_stimulus(1'b1, 32'h200, 3'd1, 32'hAABBCCDD, 2, 32'h0);
        wr_exp.push_back('{a + 1, 32'h200, 8'hDD});
        wait_lsb("sb", 1'b0);
        check_writes("sb");
        check_output("sb ram next byte", 32'(ram.exists(32'h201) ? ram[32'h201] : 8'h00), 32'h0);

        // Byte load is zero-extended; length 3 behaves as a word
        step();
        apply_stimulus(1'b0, 32'h103, 3'd1, 32'h0, 3, 32'h00000044);
        wait_lsb("lb", 1'b0);
        step();
        apply_stimulus(1'b0, 32'h100, 3'd3, 32'h0, 6, 32'h44332211);
        wait_lsb("len3", 1'b0);

        // LSB and fetch requested together: LSB first, fetch right after
        step();
        a = cyc;
        apply_stimulus(1'b0, 32'h10, 3'd2, 32'h0, 4, 32'h0000BEEF);
        if_en = 1'b1;
        if_addr = 32'h0;
        if_sb.push_back('{a + 10, 32'h00100093, 1'b1});
        wait_lsb("arb lh", 1'b0);
        wait_if("arb fetch");
        check_writes("arb");

        // Fetch aborted by rollback, then a load across rollback still completes
        step();
        base = if_done_cnt;
        if_en = 1'b1;
        if_addr = 32'h0;
        step();
        step();
        rollback = 1'b1;
        if_en = 1'b0;
        step();
        rollback = 1'b0;
        step();
        apply_stimulus(1'b0, 32'h100, 3'd2, 32'h0, 4, 32'h00002211);
        step();
        step();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        wait_lsb("lh rollback", 1'b0);
        repeat (6) step();
        check_output("rollback if_done pulses", 32'(if_done_cnt - base), 32'd0);
        check_writes("rollback");

        // IO word store held off while the sink is full
        step();
        a = cyc;
        apply_stimulus(1'b1, 32'h30004, 3'd4, 32'h12345678, 8, 32'h0);
        wr_exp.push_back('{a + 4, 32'h30004, 8'h78});
        wr_exp.push_back('{a + 5, 32'h30005, 8'h56});
        wr_exp.push_back('{a + 6, 32'h30006, 8'h34});
        wr_exp.push_back('{a + 7, 32'h30007, 8'h12});
        step();
        io_buffer_full = 1'b1;
        step();
        step();
        step();
        io_buffer_full = 1'b0;
        wait_lsb("sw io", 1'b0);
        check_writes("sw io");

        // Enable held through the done cycle must not start a second access
        step();
        base = lsb_done_cnt;
        apply_stimulus(1'b0, 32'h100, 3'd4, 32'h0, 6, 32'h44332211);
        wait_lsb("lw hold", 1'b1);
        step();
        lsb_en = 1'b0;
        repeat (8) step();
        check_output("hold done pulses", 32'(lsb_done_cnt - base), 32'd1);
        check_output("hold mem_a", mem_a, 32'h103);

        // Two frozen cycles in the middle of a word load add two cycles
        step();
        apply_stimulus(1'b0, 32'h100, 3'd4, 32'h0, 8, 32'h44332211);
        step();
        step();
        step();
        rdy = 1'b0;
        step();
        step();
        rdy = 1'b1;
        wait_lsb("lw rdy", 1'b0);
        check_writes("lw rdy");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
